// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, digit positions and field mapping for the scan driver
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [2:0] DIG_SEC_ONES = 3'd0;
    localparam logic [2:0] DIG_SEC_TENS = 3'd1;
    localparam logic [2:0] DIG_MIN_ONES = 3'd2;
    localparam logic [2:0] DIG_MIN_TENS = 3'd3;
    localparam logic [2:0] DIG_HR_ONES  = 3'd4;
    localparam logic [2:0] DIG_HR_TENS  = 3'd5;

    typedef enum logic [1:0] {
        FLD_SEC = 2'd0,
        FLD_MIN = 2'd1,
        FLD_HR  = 2'd2
    } field_e;

    function automatic field_e field_of(input logic [2:0] dig);
        return dig >= DIG_HR_ONES ? FLD_HR : dig >= DIG_MIN_ONES ? FLD_MIN : FLD_SEC;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: six-digit multiplexed clock display with per-frame snapshot,
// anti-ghost dead time, leading-zero suppression, field blinking and blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV      = 1000,
    parameter int DEAD         = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] hr_ones,
    input  logic [3:0] hr_tens,
    input  logic       blank,
    input  logic       lz_blank,
    input  logic [2:0] blink_mask,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [23:0]   shadow;
    logic [23:0]   live;
    logic [23:0]   view;
    logic          presc_wrap;
    logic          frame_start;
    logic          frame_wrap;
    logic          cnt_wrap;
    logic [3:0]    cur_bcd;
    logic [6:0]    seg_dec;
    logic          lit;

    assign live        = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
    assign presc_wrap  = presc == PW'(CLK_DIV - 1);
    assign frame_start = presc == '0 && idx == DIG_SEC_ONES;
    assign frame_wrap  = presc_wrap && idx == DIG_HR_TENS;
    assign cnt_wrap    = frame_cnt == FW'(BLINK_FRAMES - 1);
    // The snapshot cycle itself already shows the new frame's values
    assign view        = frame_start ? live : shadow;

    assign cur_bcd = idx == DIG_SEC_ONES ? view[3:0]   :
                     idx == DIG_SEC_TENS ? view[7:4]   :
                     idx == DIG_MIN_ONES ? view[11:8]  :
                     idx == DIG_MIN_TENS ? view[15:12] :
                     idx == DIG_HR_ONES  ? view[19:16] : view[23:20];

    seg7_decode u_decode (
        .bcd(cur_bcd),
        .seg(seg_dec)
    );

    assign lit = presc >= PW'(DEAD) && !blank
              && !(lz_blank && idx == DIG_HR_TENS && view[23:20] == 4'd0)
              && !(blink_phase && blink_mask[field_of(idx)]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            idx         <= DIG_SEC_ONES;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            shadow      <= '0;
            frame_tick  <= 1'b0;
            an          <= 6'h3F;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            presc <= presc_wrap ? '0 : presc + 1'b1;
            if (presc_wrap)
                idx <= idx == DIG_HR_TENS ? DIG_SEC_ONES : idx + 1'b1;
            if (frame_wrap) begin
                frame_cnt <= cnt_wrap ? '0 : frame_cnt + 1'b1;
                if (cnt_wrap)
                    blink_phase <= ~blink_phase;
            end
            if (frame_start)
                shadow <= live;
            frame_tick <= frame_start;
            an         <= lit ? ~(6'b1 << idx) : 6'h3F;
            seg        <= lit ? seg_dec : SEG_OFF;
            dp         <= !(lit && (idx == DIG_MIN_ONES || idx == DIG_HR_ONES));
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scenarios for the scan driver with a small frame model
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [23:0] v = 24'h000000;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
    logic       blank = 1'b0;
    logic       lz_blank = 1'b0;
    logic [2:0] blink_mask = 3'b000;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;
    logic [14:0] exp_v;
    int errors = 0;
    int checks = 0;

    assign {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones} = v;

    seg7_scan_driver #(.CLK_DIV(4), .DEAD(1), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .hr_ones(hr_ones), .hr_tens(hr_tens),
        .blank(blank), .lz_blank(lz_blank), .blink_mask(blink_mask),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ($countones(~an) <= 1)
            else begin
                errors++;
                $display("FAIL onehot an=%h has more than one low bit", an);
            end
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Expected {an, seg, dp, frame_tick} for sample k after reset release
    function automatic logic [14:0] expect_vec(input int k, input logic [23:0] t, input logic [5:0] dark);
        int s;
        logic lit;
        logic [5:0] ea;
        s = (k % 24) / 4;
        lit = (k % 4) != 0 && !dark[s];
        ea = lit ? ~(6'd1 << s) : 6'h3F;
        return {ea, lit ? seg_of(t[s*4 +: 4]) : 7'h7F,
                !(lit && (s == 2 || s == 4)), (k % 24) == 0};
    endfunction

    task automatic release_rst;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({an, seg, dp, frame_tick} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset got an=%h seg=%h dp=%b ft=%b want an=3f seg=7f dp=1 ft=0", an, seg, dp, frame_tick);
        end
    endtask

    task automatic test_basic;
        v = 24'h235958;
        release_rst();
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            exp_v = expect_vec(k, v, 6'h00);
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_v) begin
                errors++;
                $display("FAIL basic k=%0d got an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=%b",
                         k, an, seg, dp, frame_tick, exp_v[14:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_snapshot;
        v = 24'h123456;
        release_rst();
        for (int k = 0; k < 48; k++) begin
            if (k == 12)
                v = 24'h010000;
            @(negedge clk);
            exp_v = expect_vec(k, k < 24 ? 24'h123456 : 24'h010000, 6'h00);
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_v) begin
                errors++;
                $display("FAIL snapshot k=%0d got an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=%b",
                         k, an, seg, dp, frame_tick, exp_v[14:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_lz_blank;
        v = 24'h010000;
        lz_blank = 1'b1;
        release_rst();
        for (int k = 0; k < 48; k++) begin
            if (k == 24)
                lz_blank = 1'b0;
            @(negedge clk);
            exp_v = expect_vec(k, v, k < 24 ? 6'b100000 : 6'b000000);
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_v) begin
                errors++;
                $display("FAIL lz_blank k=%0d got an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=%b",
                         k, an, seg, dp, frame_tick, exp_v[14:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_blink;
        v = 24'h235958;
        blink_mask = 3'b010;
        release_rst();
        for (int k = 0; k < 144; k++) begin
            @(negedge clk);
            exp_v = expect_vec(k, v, ((k / 48) % 2) == 1 ? 6'b001100 : 6'b000000);
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_v) begin
                errors++;
                $display("FAIL blink k=%0d got an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=%b",
                         k, an, seg, dp, frame_tick, exp_v[14:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
        end
        blink_mask = 3'b000;
    endtask

    task automatic test_dash;
        v = 24'h2CC95C;
        release_rst();
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            exp_v = expect_vec(k, v, 6'h00);
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_v) begin
                errors++;
                $display("FAIL dash k=%0d got an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=%b",
                         k, an, seg, dp, frame_tick, exp_v[14:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic test_blank_rst;
        v = 24'h235958;
        release_rst();
        for (int k = 0; k < 14; k++) begin
            blank = k >= 6 && k <= 10;
            @(negedge clk);
            exp_v = expect_vec(k, v, (k >= 6 && k <= 10) ? 6'h3F : 6'h00);
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_v) begin
                errors++;
                $display("FAIL blank k=%0d got an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=%b",
                         k, an, seg, dp, frame_tick, exp_v[14:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
        end
        blank = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({an, seg, dp, frame_tick} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_rst got an=%h seg=%h dp=%b ft=%b want an=3f seg=7f dp=1 ft=0", an, seg, dp, frame_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_v = expect_vec(k, v, 6'h00);
            checks++;
            if ({an, seg, dp, frame_tick} !== exp_v) begin
                errors++;
                $display("FAIL restart k=%0d got an=%h seg=%h dp=%b ft=%b want an=%h seg=%h dp=%b ft=%b",
                         k, an, seg, dp, frame_tick, exp_v[14:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_lz_blank();
        test_blink();
        test_dash();
        test_blank_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter CLK_DIV, default 1000, is the number of clk cycles per digit slot (minimum 4).
REQ-002 Parameter DEAD, default 2, is the number of anti-ghost cycles at the start of each slot with all anodes off (less than CLK_DIV).
REQ-003 Parameter BLINK_FRAMES, default 64, is the number of frames per blink half-period.
REQ-004 The reset shall be rst, asynchronous, active-high, and the clock shall be clk.
REQ-005 Port clk  in  1  system clock.
REQ-006 Port rst  in  1  asynchronous active-high reset.
REQ-007 Ports sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens  in  4 each  BCD time digits.
REQ-008 Port blank  in  1  forces all anodes off.
REQ-009 Port lz_blank  in  1  suppresses a zero hr_tens digit.
REQ-010 Port blink_mask  in  3  field blink enables: bit0 = seconds, bit1 = minutes, bit2 = hours.
REQ-011 Port an  out  6  active-low anodes: bit i = digit i, with 0 = sec_ones through 5 = hr_tens.
REQ-012 Port seg  out  7  active-low segments ordered {g,f,e,d,c,b,a}.
REQ-013 Port dp  out  1  active-low decimal point.
REQ-014 Port frame_tick  out  1  one-cycle pulse at each snapshot.

Function
REQ-015 The prescaler shall count 0..CLK_DIV-1 and wrap to 0; the digit index shall advance 0→1→…→5→0 on each prescaler wrap.
REQ-016 Frame start is defined as prescaler==0 && index==0; at frame start all six inputs shall be latched into shadow registers, and display shall use only the shadow values (no tearing mid-frame).
REQ-017 frame_tick shall be asserted on the cycle after frame start, for exactly one cycle.
REQ-018 Decode shall map 0–9 to standard patterns (0=7'h40, 1=7'h79, 8=7'h00) and 10–15 to a dash (7'h3F).
REQ-019 The anode for the current index shall be driven low only while prescaler ≥ DEAD; all other anodes shall be high.
REQ-020 dp shall be driven low while digit 2 or digit 4 is active (separators); otherwise dp shall be high.
REQ-021 When lz_blank=1 and shadow hr_tens==0, digit 5 shall keep its anode high for the whole slot.
REQ-022 The frame counter shall count frames 0..BLINK_FRAMES-1, and blink_phase shall toggle at each wrap.
REQ-023 While blink_phase=1, the anodes of fields whose blink_mask bit is set shall be held high; blink_mask is sampled live, not shadowed.
REQ-024 blank=1 shall force an=6'h3F and dp=1 with one-cycle latency; the counters and snapshot shall continue to run.
REQ-025 an, seg and dp shall be registered outputs reflecting the prescaler/index state of the previous cycle (latency 1).
REQ-026 When an=6'h3F, seg shall be 7'h7F and dp shall be 1 (fully dark).
REQ-027 More than one anode shall never be low in the same cycle.

Reset
REQ-028 On rst the following shall apply: an=6'h3F, seg=7'h7F, dp=1, frame_tick=0; prescaler, index, frame counter and blink_phase = 0; shadow digits = 0.
REQ-029 The first cycle after rst deassertion shall be a frame start and shall take a snapshot.
REQ-030 An rst asserted mid-frame shall darken all outputs immediately (asynchronously) and discard the partial frame.

Structure
REQ-031 Package seg7_pkg shall hold the segment constants SEG_0..SEG_9, SEG_DASH and SEG_OFF, the digit-index constants DIG_SEC_ONES..DIG_HR_TENS, and the field-to-digit mapping.
REQ-032 Sub-module seg7_decode shall convert 4-bit BCD to 7-bit active-low segments combinationally; all sequential logic shall remain in seg7_scan_driver.

Verification (CLK_DIV=4, DEAD=1, BLINK_FRAMES=2)
REQ-033 Inputs 23:59:58, release reset: over one 24-cycle frame each anode shall be low for 3 cycles in order 0..5, with seg = SEG_8, SEG_5, SEG_9, SEG_5, SEG_3, SEG_2, and dp low on digits 2 and 4.
REQ-034 Inputs change from 12:34:56 to 01:00:00 mid-frame: the remainder of the frame shall still show 12:34:56, and the next frame shall show 01:00:00 with a frame_tick pulse.
REQ-035 lz_blank=1 with hr_tens=0: digit 5 slot shall be fully dark; lz_blank=0: digit 5 shall show SEG_0.
REQ-036 blink_mask=3'b010: minutes digits shall be dark in frames 2–3, lit in frames 0–1 and 4–5; seconds and hours always lit.
REQ-037 Any BCD input = 4'hC: that digit shall show 7'h3F; assertion check: at most one anode low every cycle.
REQ-038 blank pulsed for 5 cycles, then rst asserted mid-slot: an=6'h3F one cycle after blank rises; on rst, an=6'h3F immediately, and restart shall begin a new frame at digit 0.
